// File: rtl/request_encoder.sv
// Sequential 8:3 request encoder: pending-request register, one 3-bit code offered per valid/accept handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest pending index wins.
module request_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [7:0] R,
  input  logic       A,
  output logic       V,
  output logic [2:0] S,
  output logic [7:0] P,
  output logic       OVF
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state, state_nxt;
  logic       v_nxt, ovf_nxt, acc;
  logic [2:0] s_nxt;
  logic [7:0] clr, rem, p_nxt;

`ifdef ROUND_ROBIN_EN
  logic [2:0] last, last_nxt;

  // Searches upward starting just after 'after', wrapping 7 -> 0.
  function automatic logic [2:0] sel(input logic [7:0] vec, input logic [2:0] after);
    logic [2:0] idx;
    logic       found;
    sel   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = after + 3'(k);
      if (!found && vec[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction
`else
  function automatic logic [2:0] sel(input logic [7:0] vec);
    sel = 3'd0;
    for (int i = 0; i < 8; i++)
      if (vec[i]) sel = 3'(i);
  endfunction
`endif

  // Disabled offers are withdrawn without retiring the offered bit.
  always_comb begin
    acc     = (state == OFFER) && A && E;
    clr     = acc ? (8'd1 << S) : 8'd0;
    rem     = P & ~clr;
    p_nxt   = rem | (E ? R : 8'h00);
    ovf_nxt = E & (|(R & P & ~clr));
  end

  always_comb begin
    state_nxt = state;
    v_nxt     = V;
    s_nxt     = S;
`ifdef ROUND_ROBIN_EN
    last_nxt  = acc ? S : last;
`endif
    case (state)
      IDLE: begin
        v_nxt = 1'b0;
        if (E && (|P)) begin
`ifdef ROUND_ROBIN_EN
          s_nxt = sel(P, last);
`else
          s_nxt = sel(P);
`endif
          v_nxt     = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (!E) begin
          v_nxt     = 1'b0;
          state_nxt = IDLE;
        end else if (A) begin
          if (|rem) begin
`ifdef ROUND_ROBIN_EN
            s_nxt = sel(rem, S);
`else
            s_nxt = sel(rem);
`endif
          end else begin
            v_nxt     = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        v_nxt     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      V     <= 1'b0;
      S     <= 3'd0;
      P     <= 8'h00;
      OVF   <= 1'b0;
    end else begin
      state <= state_nxt;
      V     <= v_nxt;
      S     <= s_nxt;
      P     <= p_nxt;
      OVF   <= ovf_nxt;
    end
  end

`ifdef ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= 3'd7;
    else        last <= last_nxt;
  end
`endif

endmodule

// File: tb/tb_request_encoder.sv
// Directed bench for request_encoder; expected codes follow the ROUND_ROBIN_EN build selection.
module tb_request_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       E = 1'b0;
  logic [7:0] R = 8'h00;
  logic       A = 1'b0;
  logic       V;
  logic [2:0] S;
  logic [7:0] P;
  logic       OVF;

  int total = 0;
  int bad   = 0;

`ifdef ROUND_ROBIN_EN
  localparam logic [2:0] PRI_91_0 = 3'd0, PRI_91_1 = 3'd4, PRI_91_2 = 3'd7;
  localparam logic [2:0] PRI_81_0 = 3'd0, PRI_81_1 = 3'd7;
  localparam logic [2:0] OV_S1 = 3'd2, OV_S2 = 3'd5;
`else
  localparam logic [2:0] PRI_91_0 = 3'd7, PRI_91_1 = 3'd4, PRI_91_2 = 3'd0;
  localparam logic [2:0] PRI_81_0 = 3'd7, PRI_81_1 = 3'd0;
  localparam logic [2:0] OV_S1 = 3'd5, OV_S2 = 3'd2;
`endif

  request_encoder dut (
    .clk(clk), .rst_n(rst_n), .E(E), .R(R), .A(A),
    .V(V), .S(S), .P(P), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; E = 1'b0; R = 8'h00; A = 1'b0;
    tick();
    rst_n = 1'b1;
    E = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; R = 8'hFF; E = 1'b1; A = 1'b1;
    tick(); tick();
    total++; if (V !== 1'b0)   begin bad++; $display("FAIL reset_V got=%b want=0", V); end
    total++; if (S !== 3'd0)   begin bad++; $display("FAIL reset_S got=%0d want=0", S); end
    total++; if (P !== 8'h00)  begin bad++; $display("FAIL reset_P got=%h want=00", P); end
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL reset_OVF got=%b want=0", OVF); end
    R = 8'h00; A = 1'b0; E = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    apply_reset();
    R = 8'h20; tick(); R = 8'h00;
    total++; if (P !== 8'h20) begin bad++; $display("FAIL single_P1 got=%h want=20", P); end
    total++; if (V !== 1'b0)  begin bad++; $display("FAIL single_V1 got=%b want=0", V); end
    tick();
    total++; if (V !== 1'b1 || S !== 3'd5) begin bad++; $display("FAIL single_offer got V=%b S=%0d want V=1 S=5", V, S); end
    A = 1'b1; tick(); A = 1'b0;
    total++; if (P !== 8'h00 || V !== 1'b0) begin bad++; $display("FAIL single_accept got P=%h V=%b want P=00 V=0", P, V); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp91 [3];
    exp91[0] = PRI_91_0; exp91[1] = PRI_91_1; exp91[2] = PRI_91_2;
    apply_reset();
    A = 1'b1; R = 8'h91; tick(); R = 8'h00;
    total++; if (P !== 8'h91 || V !== 1'b0) begin bad++; $display("FAIL b2b_capture got P=%h V=%b want P=91 V=0", P, V); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (V !== 1'b1 || S !== exp91[i]) begin bad++; $display("FAIL b2b_91_code%0d got V=%b S=%0d want V=1 S=%0d", i, V, S, exp91[i]); end
    end
    tick();
    total++; if (V !== 1'b0 || P !== 8'h00) begin bad++; $display("FAIL b2b_91_drain got V=%b P=%h want V=0 P=00", V, P); end
    R = 8'h81; tick(); R = 8'h00;
    tick();
    total++; if (V !== 1'b1 || S !== PRI_81_0) begin bad++; $display("FAIL b2b_81_code0 got V=%b S=%0d want V=1 S=%0d", V, S, PRI_81_0); end
    tick();
    total++; if (V !== 1'b1 || S !== PRI_81_1) begin bad++; $display("FAIL b2b_81_code1 got V=%b S=%0d want V=1 S=%0d", V, S, PRI_81_1); end
    tick(); A = 1'b0;
    total++; if (V !== 1'b0 || P !== 8'h00) begin bad++; $display("FAIL b2b_81_drain got V=%b P=%h want V=0 P=00", V, P); end
  endtask

  task automatic test_overflow;
    apply_reset();
    R = 8'h24; tick(); R = 8'h00; tick();
    total++; if (V !== 1'b1 || S !== OV_S1) begin bad++; $display("FAIL ovf_offer got V=%b S=%0d want V=1 S=%0d", V, S, OV_S1); end
    R = 8'h04; tick(); R = 8'h00;
    total++; if (OVF !== 1'b1 || P !== 8'h24) begin bad++; $display("FAIL ovf_pulse got OVF=%b P=%h want OVF=1 P=24", OVF, P); end
    tick();
    total++; if (OVF !== 1'b0 || V !== 1'b1 || S !== OV_S1) begin bad++; $display("FAIL ovf_single got OVF=%b V=%b S=%0d want OVF=0 V=1 S=%0d", OVF, V, S, OV_S1); end
    A = 1'b1; R = 8'd1 << OV_S1; tick(); R = 8'h00;
    total++; if (OVF !== 1'b0 || P !== 8'h24) begin bad++; $display("FAIL collide_keep got OVF=%b P=%h want OVF=0 P=24", OVF, P); end
    total++; if (V !== 1'b1 || S !== OV_S2) begin bad++; $display("FAIL collide_next got V=%b S=%0d want V=1 S=%0d", V, S, OV_S2); end
    tick();
    total++; if (V !== 1'b1 || S !== OV_S1) begin bad++; $display("FAIL collide_reoffer got V=%b S=%0d want V=1 S=%0d", V, S, OV_S1); end
    tick(); A = 1'b0;
    total++; if (V !== 1'b0 || P !== 8'h00) begin bad++; $display("FAIL collide_drain got V=%b P=%h want V=0 P=00", V, P); end
  endtask

  task automatic test_enable_drop;
    apply_reset();
    R = 8'h40; tick(); R = 8'h00; tick();
    total++; if (V !== 1'b1 || S !== 3'd6) begin bad++; $display("FAIL en_offer got V=%b S=%0d want V=1 S=6", V, S); end
    E = 1'b0; A = 1'b1; R = 8'h01; tick();
    A = 1'b0; R = 8'h00;
    total++; if (V !== 1'b0 || P !== 8'h40 || OVF !== 1'b0) begin bad++; $display("FAIL en_drop got V=%b P=%h OVF=%b want V=0 P=40 OVF=0", V, P, OVF); end
    E = 1'b1; tick();
    total++; if (V !== 1'b1 || S !== 3'd6) begin bad++; $display("FAIL en_resume got V=%b S=%0d want V=1 S=6", V, S); end
    A = 1'b1; tick(); A = 1'b0;
    total++; if (V !== 1'b0 || P !== 8'h00) begin bad++; $display("FAIL en_drain got V=%b P=%h want V=0 P=00", V, P); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    R = 8'h08; tick(); R = 8'h00; tick();
    total++; if (V !== 1'b1 || S !== 3'd3) begin bad++; $display("FAIL arst_offer got V=%b S=%0d want V=1 S=3", V, S); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (V !== 1'b0 || P !== 8'h00) begin bad++; $display("FAIL arst_drop got V=%b P=%h want V=0 P=00", V, P); end
    tick();
    rst_n = 1'b1; tick(); tick();
    total++; if (V !== 1'b0 || P !== 8'h00) begin bad++; $display("FAIL arst_idle got V=%b P=%h want V=0 P=00", V, P); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
